// File: rtl/xoodoo_duplex_pkg.sv
// Shared definitions for the Xoodoo duplex wrapper.
//   STATE_W : width of the Xoodoo state in bits, [0:STATE_W-1] ordering
//   CD_LSB  : first state bit of the domain-separation byte
//   CD_W    : width of the domain-separation byte
//   COUNT_W : width of the completed-permutation counter
//   state_e : duplex controller FSM states
package xoodoo_duplex_pkg;

  localparam int STATE_W = 384;
  localparam int CD_LSB  = 376;
  localparam int CD_W    = 8;
  localparam int COUNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_e;

endpackage

// File: rtl/xoodoo_duplex_if.sv
// Absorb/squeeze handshake bundle of the Xoodoo duplex wrapper.
//   in_valid/in_ready   : absorb-block handshake
//   in_data             : rate block, bit i lands on state bit i
//   in_cd               : domain byte for state bits [376:383]
//   in_last             : marks the final block of a message
//   out_valid/out_ready : squeeze handshake
//   out_data            : rate part of the permuted state
// The master side is the client of the duplex; the slave side is the duplex.
interface xoodoo_duplex_if
  import xoodoo_duplex_pkg::*;
#(
  parameter int RATE_BITS = 128
);

  logic                 in_valid;
  logic                 in_ready;
  logic [0:RATE_BITS-1] in_data;
  logic [CD_W-1:0]      in_cd;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [0:RATE_BITS-1] out_data;

  modport master (
    output in_valid, in_data, in_cd, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_cd, in_last, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/xoodoo_duplex.sv
// Xoodoo duplex controller: absorbs one rate block plus domain byte into the
// 384-bit state, hands the state to an external Xoodoo permutation, then
// offers the rate part of the permuted state for squeezing.
//   clk            : single clock, rising edge
//   resetn         : asynchronous reset, active high
//   bus            : absorb/squeeze handshake (slave side)
//   perm_enable    : start/hold request to the permutation (LOAD and WAIT)
//   perm_state_out : current state, always equal to the internal state
//   perm_state_in  : permuted state returned by the permutation
//   perm_done      : permutation complete (level or pulse, used only in WAIT)
//   perm_count     : completed permutations, wraps at 16'hFFFF
//   timeout_err    : sticky, set when a permutation overruns TIMEOUT cycles
module xoodoo_duplex
  import xoodoo_duplex_pkg::*;
#(
  parameter int RATE_BITS = 128,
  parameter int TIMEOUT   = 64
)
(
  input  logic               clk,
  input  logic               resetn,
  xoodoo_duplex_if.slave     bus,
  output logic               perm_enable,
  output logic [0:STATE_W-1] perm_state_out,
  input  logic [0:STATE_W-1] perm_state_in,
  input  logic               perm_done,
  output logic [15:0]        perm_count,
  output logic               timeout_err
);

  // One extra bit so TIMEOUT-1 always fits, including power-of-two values.
  localparam int WCNT_W = $clog2(TIMEOUT) + 1;

  state_e               state_q, state_d;
  logic [0:STATE_W-1]   s_q, s_d;
  logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
  logic                 last_q, last_d;
  logic [COUNT_W-1:0]   perm_count_q, perm_count_d;
  logic                 terr_q, terr_d;

  // in_ready is masked while reset is held so it reads 0 even though the
  // FSM already sits in IDLE.
  assign bus.in_ready    = (state_q == IDLE) && !resetn;
  assign bus.out_valid   = (state_q == OUT);
  assign bus.out_data    = s_q[0 +: RATE_BITS];
  assign perm_enable     = (state_q == LOAD) || (state_q == WAIT);
  assign perm_state_out  = s_q;
  assign perm_count      = perm_count_q;
  assign timeout_err     = terr_q;

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    wcnt_d       = wcnt_q;
    last_d       = last_q;
    perm_count_d = perm_count_q;
    terr_d       = terr_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && bus.in_ready) begin
          s_d[0 +: RATE_BITS] = s_q[0 +: RATE_BITS] ^ bus.in_data;
          // Applied on top of s_d so a rate overlapping the domain byte
          // still sees both contributions.
          s_d[CD_LSB +: CD_W] = s_d[CD_LSB +: CD_W] ^ bus.in_cd;
          last_d              = bus.in_last;
          state_d             = LOAD;
        end
      end
      LOAD: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // done has priority over an expiring timeout in the same cycle.
        if (perm_done) begin
          s_d          = perm_state_in;
          perm_count_d = perm_count_q + COUNT_W'(1);
          state_d      = OUT;
        end else if (wcnt_q == WCNT_W'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          if (last_q) begin
            s_d = '0;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q      <= IDLE;
      s_q          <= '0;
      wcnt_q       <= '0;
      last_q       <= 1'b0;
      perm_count_q <= '0;
      terr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      wcnt_q       <= wcnt_d;
      last_q       <= last_d;
      perm_count_q <= perm_count_d;
      terr_q       <= terr_d;
    end
  end

endmodule

// File: tb/tb_xoodoo_duplex.sv
// Scoreboard bench for xoodoo_duplex: a stub permutation XORs a mask into the
// presented state after a programmable number of cycles; expected squeeze
// results are queued at issue time and checked by an independent monitor.
module tb_xoodoo_duplex;
  import xoodoo_duplex_pkg::*;

  localparam int RB = 128;
  localparam int TO = 64;

  logic               clk = 1'b0;
  logic               resetn;
  logic               perm_enable;
  logic [0:STATE_W-1] perm_state_out;
  logic [0:STATE_W-1] perm_state_in;
  logic               perm_done;
  logic [15:0]        perm_count;
  logic               timeout_err;

  always #5 clk = ~clk;

  xoodoo_duplex_if #(.RATE_BITS(RB)) bus();

  xoodoo_duplex #(.RATE_BITS(RB), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .bus            (bus),
    .perm_enable    (perm_enable),
    .perm_state_out (perm_state_out),
    .perm_state_in  (perm_state_in),
    .perm_done      (perm_done),
    .perm_count     (perm_count),
    .timeout_err    (timeout_err)
  );

  // Stub permutation: done (level) once enable has been seen stub_delay edges.
  int                 stub_delay = 5;
  int                 stub_cnt   = 0;
  logic [0:STATE_W-1] stub_mask;

  always @(posedge clk) begin
    if (!perm_enable) stub_cnt <= 0;
    else              stub_cnt <= stub_cnt + 1;
  end
  assign perm_done     = (stub_delay > 0) && (stub_cnt >= stub_delay);
  assign perm_state_in = perm_state_out ^ stub_mask;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [0:RB-1] data;
    logic [15:0]   cnt;
  } exp_t;
  exp_t exp_q[$];

  logic [0:STATE_W-1] model_s;
  logic [15:0]        cnt_model;

  task automatic chk(input string name, input logic [383:0] act, input logic [383:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every squeeze handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (resetn === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_squeeze actual=%0h required=none", bus.out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("squeeze_data", bus.out_data, e.data);
        chk("squeeze_perm_count", perm_count, e.cnt);
      end
    end
  end

  task automatic absorb(input logic [0:RB-1] d, input logic [7:0] cd, input logic last);
    int n;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_cd    = cd;
    bus.in_last  = last;
    n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("absorb_in_ready", bus.in_ready, 1);
    model_s[0 +: RB]      = model_s[0 +: RB] ^ d;
    model_s[CD_LSB +: 8]  = model_s[CD_LSB +: 8] ^ cd;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("load_state", perm_state_out, model_s);
    chk("load_perm_enable", perm_enable, 1);
    chk("load_in_ready", bus.in_ready, 0);
  endtask

  // Queue the result the stub permutation will produce from the model state.
  task automatic expect_perm();
    exp_t e;
    model_s   = model_s ^ stub_mask;
    cnt_model = cnt_model + 16'd1;
    e.data    = model_s[0 +: RB];
    e.cnt     = cnt_model;
    exp_q.push_back(e);
  endtask

  task automatic squeeze(input int hold, input logic last);
    int n;
    logic [0:RB-1] held;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_arrives", bus.out_valid, 1);
    held = bus.out_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_out_data", bus.out_data, held);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    if (last) model_s = '0;
    @(negedge clk);
    chk("post_squeeze_state", perm_state_out, model_s);
    chk("post_squeeze_in_ready", bus.in_ready, 1);
    chk("post_squeeze_out_valid", bus.out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int  n;
    logic seen_valid;

    resetn        = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_cd     = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    stub_mask     = {48{8'hA5}};
    model_s       = '0;
    cnt_model     = '0;

    // Reset state, observed while reset is still held.
    #1;
    chk("reset_in_ready", bus.in_ready, 0);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_perm_enable", perm_enable, 0);
    chk("reset_perm_count", perm_count, 0);
    chk("reset_timeout_err", timeout_err, 0);
    chk("reset_state", perm_state_out, 0);
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b0;
    @(negedge clk);
    chk("release_in_ready", bus.in_ready, 1);

    // Zero block with domain byte 03, output held for 10 cycles.
    stub_delay = 5;
    absorb(128'h0, 8'h03, 1'b0);
    chk("load_cd_only", perm_state_out, 384'h03);
    expect_perm();
    squeeze(10, 1'b0);
    chk("first_out_pattern", model_s[0 +: RB], {16{8'hA5}});

    // Final block: state must clear after its squeeze.
    stub_delay = 1;
    absorb(128'h0123456789ABCDEF_FEDCBA9876543210, 8'h01, 1'b1);
    expect_perm();
    squeeze(0, 1'b1);
    chk("last_clears_state", perm_state_out, 0);

    // Different mask and all-ones data, state kept afterwards.
    stub_delay = 3;
    stub_mask  = {12{32'hDEADBEEF}};
    absorb({RB{1'b1}}, 8'h80, 1'b0);
    expect_perm();
    squeeze(2, 1'b0);

    // Permutation never completes: timeout after 64 WAIT cycles.
    stub_delay = 0;
    absorb(128'h5A5A_0000_1111_2222_3333_4444_5555_6666, 8'h06, 1'b0);
    n = 0;
    seen_valid = 1'b0;
    while (timeout_err !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (bus.out_valid === 1'b1) seen_valid = 1'b1;
    end
    chk("timeout_edges", n, 65);
    chk("timeout_err_set", timeout_err, 1);
    chk("timeout_no_squeeze", seen_valid, 0);
    @(negedge clk);
    chk("timeout_idle_in_ready", bus.in_ready, 1);
    chk("timeout_state_kept", perm_state_out, model_s);
    chk("timeout_count_kept", perm_count, cnt_model);

    // Normal block after a timeout; the error flag stays set.
    stub_delay = 2;
    absorb(128'h1, 8'h00, 1'b1);
    expect_perm();
    squeeze(0, 1'b1);
    chk("timeout_err_sticky", timeout_err, 1);

    // Counter wrap from 16'hFFFF.
    @(negedge clk);
    dut.perm_count_q = 16'hFFFF;
    cnt_model        = 16'hFFFF;
    @(negedge clk);
    chk("preload_count", perm_count, 16'hFFFF);
    absorb(128'hCAFE, 8'h0F, 1'b1);
    expect_perm();
    squeeze(0, 1'b1);
    chk("count_wrapped", perm_count, 0);

    // Reset pulsed in the middle of WAIT abandons the permutation.
    stub_delay = 5;
    absorb(128'hFACE, 8'h33, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    chk("mid_wait_enable", perm_enable, 1);
    resetn = 1'b1;
    #1;
    chk("midreset_in_ready", bus.in_ready, 0);
    chk("midreset_out_valid", bus.out_valid, 0);
    chk("midreset_perm_enable", perm_enable, 0);
    chk("midreset_perm_count", perm_count, 0);
    chk("midreset_timeout_err", timeout_err, 0);
    chk("midreset_state", perm_state_out, 0);
    @(posedge clk); #1;
    resetn    = 1'b0;
    model_s   = '0;
    cnt_model = '0;
    @(negedge clk);
    chk("midreset_release_in_ready", bus.in_ready, 1);
    repeat (10) @(negedge clk);
    chk("midreset_no_squeeze", bus.out_valid, 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xoodoo_duplex.md
XOODOO_DUPLEX -- requirements
Module: xoodoo_duplex

Interface
REQ-001 Parameter: RATE_BITS, default 128, absorb/squeeze block width in state bits [0:RATE_BITS-1].
REQ-002 Parameter: TIMEOUT, default 64, maximum cycles to wait for permutation completion.
REQ-003 Port: clk  in  1  single clock; all state on rising edge.
REQ-004 Port: resetn  in  1  asynchronous, active-high reset (the name follows the codebase convention; polarity is active-high).
REQ-005 Port: in_valid / in_ready  in / out  1 / 1  absorb-block handshake.
REQ-006 Port: in_data  in  RATE_BITS  block XORed into state bits [0:RATE_BITS-1].
REQ-007 Port: in_cd  in  8  domain byte XORed into state bits [376:383].
REQ-008 Port: in_last  in  1  final block of a message; state clears after its squeeze.
REQ-009 Port: perm_enable  out  1  start/hold to the Xoodoo permutation block.
REQ-010 Port: perm_state_out  out  384  state presented to the permutation, [0:383] ordering.
REQ-011 Port: perm_state_in  in  384  permuted state returned.
REQ-012 Port: perm_done  in  1  permutation complete, level or pulse.
REQ-013 Port: out_valid / out_ready  out / in  1 / 1  squeeze handshake.
REQ-014 Port: out_data  out  RATE_BITS  state bits [0:RATE_BITS-1] after permutation.
REQ-015 Port: perm_count  out  16  completed permutations, wraps at 16'hFFFF -> 0.
REQ-016 Port: timeout_err  out  1  sticky; permutation did not finish within TIMEOUT.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, WAIT and OUT.
REQ-018 In IDLE, in_ready SHALL be 1; otherwise it SHALL be 0.
REQ-019 On in_valid&in_ready, the block SHALL update S[0:RATE_BITS-1] ^= in_data and S[376:383] ^= in_cd, latch in_last, and go to LOAD.
REQ-020 In LOAD and WAIT, perm_enable SHALL be 1; in IDLE and OUT it SHALL be 0.
REQ-021 perm_state_out SHALL equal S continuously.
REQ-022 LOAD SHALL last exactly one cycle, then go to WAIT with the wait counter cleared.
REQ-023 In WAIT, perm_done SHALL be sampled.
REQ-024 On perm_done=1 in WAIT, the block SHALL set S <= perm_state_in, increment perm_count, and go to OUT.
REQ-025 perm_done outside WAIT SHALL be ignored.
REQ-026 The wait counter SHALL increment each WAIT cycle without done.
REQ-027 If the wait counter reaches TIMEOUT-1 without done, the block SHALL set timeout_err, leave S unchanged, and return to IDLE with no squeeze.
REQ-028 If done and the timeout occur in the same cycle, done SHALL win.
REQ-029 In OUT, out_valid SHALL be 1 and out_data SHALL equal S[0:RATE_BITS-1], held stable until out_ready.
REQ-030 On out_valid&out_ready, the block SHALL go to IDLE, clearing S to 0 if the latched last flag is 1 and otherwise keeping S.
REQ-031 Minimum latency, input accept to out_valid, SHALL be 2 cycles plus the permutation's done latency.
REQ-032 A back-to-back block SHALL be accepted no earlier than the cycle after the squeeze handshake.
REQ-033 timeout_err SHALL clear only on reset.

Reset
REQ-034 While resetn=1, asynchronously: FSM=IDLE, S=0, perm_count=0, wait counter=0, last flag=0, timeout_err=0.
REQ-035 While resetn=1, outputs SHALL read in_ready=0, out_valid=0, perm_enable=0.
REQ-036 A reset mid-WAIT SHALL abandon the permutation.
REQ-037 After reset release, in_ready SHALL be 1 on the first clock in IDLE.

Structure
REQ-038 A shared package SHALL hold STATE_W=384, CD_LSB=376, and the FSM state enum.
REQ-039 The block SHALL contain no sub-module; the permutation instance stays outside and connects via the perm_* ports.

Verification
REQ-040 Reset, then in_data=0, in_cd=8'h03 -> in LOAD, perm_state_out has bits [376:383]=8'h03 and all other bits 0; perm_enable=1.
REQ-041 Stub returns perm_state_in=384'hA5.. with done after 5 WAIT cycles -> out_valid, out_data=128'hA5A5..A5, perm_count=1.
REQ-042 out_ready held 0 for 10 cycles -> out_data stable and in_ready=0 throughout; in_last=1 with out_ready=1 -> S=0 afterwards.
REQ-043 perm_done never asserted -> after 64 WAIT cycles timeout_err=1, FSM=IDLE, out_valid never 1.
REQ-044 resetn pulsed during WAIT -> all outputs return to reset values and in_ready=1 on the next clock.
REQ-045 Preload perm_count=16'hFFFF, then one more permutation -> perm_count=0.
